// File: rtl/mdio_pkg.sv
// mdio_pkg: shared definitions for the Clause-22 MDIO slave.
//   mdio_state_e : frame FSM states
//   MDIO_OP_*    : OP field encodings
//   MDIO_ST      : start-of-frame code
//   field widths and bit counts used by the frame parser
package mdio_pkg;

    typedef enum logic [2:0] {
        S_PRE   = 3'd0,
        S_ST    = 3'd1,
        S_OP    = 3'd2,
        S_PHYAD = 3'd3,
        S_REGAD = 3'd4,
        S_TA    = 3'd5,
        S_DATA  = 3'd6,
        S_SKIP  = 3'd7
    } mdio_state_e;

    localparam logic [1:0] MDIO_OP_WR = 2'b01;
    localparam logic [1:0] MDIO_OP_RD = 2'b10;
    localparam logic [1:0] MDIO_ST    = 2'b01;

    localparam int unsigned CNT_W     = 5;
    localparam int unsigned OP_BITS   = 2;
    localparam int unsigned ADDR_W    = 5;
    localparam int unsigned TA_BITS   = 2;
    localparam int unsigned DATA_W    = 16;
    // TA + DATA bits left after REGAD in a frame addressed to another PHY
    localparam int unsigned SKIP_BITS = 18;

endpackage

// File: rtl/mdio_sync_edge.sv
// mdio_sync_edge: 2-flop synchronizer with registered rise detect.
//   clk_i  : system clock
//   rstn_i : async active-low reset
//   d_i    : asynchronous input
//   q_o    : synchronized level
//   rise_o : one-cycle pulse in the first cycle q_o is high
module mdio_sync_edge (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic d_i,
    output logic q_o,
    output logic rise_o
);

    logic [1:0] sync_q;

    // rise_o is registered so it lines up with the cycle q_o goes high
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync_q <= 2'b00;
            rise_o <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], d_i};
            rise_o <= sync_q[0] & ~sync_q[1];
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/mdio_slave.sv
// mdio_slave: Clause-22 MDIO management slave, oversampling MDC with clk_i.
//   clk_i, rstn_i            : system clock, async active-low reset
//   mdc_i, mdio_i            : MDIO pad clock / data in (async to clk_i)
//   mdio_o, mdio_oe_o        : MDIO pad data out / output enable
//   reg_addr_o, reg_wdata_o  : register address and write data
//   reg_wr_o, reg_rd_o       : one-cycle write / read strobes
//   reg_rdata_i              : read data, valid one cycle after reg_rd_o
// Optional: define MDIO_PREAMBLE_SUPPRESS_EN to accept a frame after a
// single idle 1-bit following a completed addressed frame.
module mdio_slave
    import mdio_pkg::*;
#(
    parameter logic [4:0]  PHY_ADDR = 5'h1F,
    parameter int unsigned PRE_LEN  = 32
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                mdc_i,
    input  logic                mdio_i,
    output logic                mdio_o,
    output logic                mdio_oe_o,
    output logic [ADDR_W-1:0]   reg_addr_o,
    output logic [DATA_W-1:0]   reg_wdata_o,
    output logic                reg_wr_o,
    output logic                reg_rd_o,
    input  logic [DATA_W-1:0]   reg_rdata_i
);

    localparam int unsigned PRE_W = $clog2(PRE_LEN + 1);

    logic mdc_s, mdc_rise, mdio_s, mdio_rise;
    logic unused_c;

    mdio_sync_edge u_sync_mdc (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .d_i    (mdc_i),
        .q_o    (mdc_s),
        .rise_o (mdc_rise)
    );

    mdio_sync_edge u_sync_mdio (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .d_i    (mdio_i),
        .q_o    (mdio_s),
        .rise_o (mdio_rise)
    );

    assign unused_c = &{1'b0, mdc_s, mdio_rise};

    mdio_state_e         state_q, state_d;
    logic [PRE_W-1:0]    pre_cnt_q;
    logic [CNT_W-1:0]    bit_cnt_q;
    logic [DATA_W-1:0]   sh_q;
    logic [DATA_W-1:0]   rd_sh_q;
    logic                op_rd_q;
    logic                phy_match_q;
    logic                rd_cap_q;
    logic [1:0]          op_c;
    logic                pre_full_c;
    logic                pre_ok_c;
    logic                rd_shift_c;
    logic                data_last_c;

    assign op_c        = {sh_q[0], mdio_s};
    assign pre_full_c  = (pre_cnt_q == PRE_W'(PRE_LEN));
    assign data_last_c = (bit_cnt_q == CNT_W'(DATA_W - 1));

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    logic supp_ok_q;

    // Armed by a completed addressed frame, consumed by the next ST
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            supp_ok_q <= 1'b0;
        end else if (mdc_rise) begin
            if (state_q == S_DATA && data_last_c) begin
                supp_ok_q <= 1'b1;
            end else if (state_q == S_PRE && state_d == S_ST) begin
                supp_ok_q <= 1'b0;
            end
        end
    end

    assign pre_ok_c = pre_full_c || (supp_ok_q && (pre_cnt_q != '0));
`else
    assign pre_ok_c = pre_full_c;
`endif

    // Read shifter advances on the rises that put a new data bit on the pad
    assign rd_shift_c = mdc_rise && op_rd_q &&
                        ((state_q == S_TA && bit_cnt_q == CNT_W'(TA_BITS - 1)) ||
                         (state_q == S_DATA && !data_last_c));

    // State register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= S_PRE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; only MDC rising edges advance the frame
    always_comb begin
        state_d = state_q;
        if (mdc_rise) begin
            case (state_q)
                S_PRE: begin
                    if (mdio_s == MDIO_ST[1] && pre_ok_c) begin
                        state_d = S_ST;
                    end
                end
                S_ST: begin
                    state_d = (mdio_s == MDIO_ST[0]) ? S_OP : S_PRE;
                end
                S_OP: begin
                    if (bit_cnt_q == CNT_W'(OP_BITS - 1)) begin
                        state_d = (op_c == MDIO_OP_WR || op_c == MDIO_OP_RD) ? S_PHYAD : S_PRE;
                    end
                end
                S_PHYAD: begin
                    if (bit_cnt_q == CNT_W'(ADDR_W - 1)) begin
                        state_d = S_REGAD;
                    end
                end
                S_REGAD: begin
                    if (bit_cnt_q == CNT_W'(ADDR_W - 1)) begin
                        state_d = phy_match_q ? S_TA : S_SKIP;
                    end
                end
                S_TA: begin
                    if (bit_cnt_q == CNT_W'(TA_BITS - 1)) begin
                        state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    if (data_last_c) begin
                        state_d = S_PRE;
                    end
                end
                S_SKIP: begin
                    if (bit_cnt_q == CNT_W'(SKIP_BITS - 1)) begin
                        state_d = S_PRE;
                    end
                end
                default: state_d = S_PRE;
            endcase
        end
    end

    // Frame datapath: counters, input shifter, pad drive and strobes
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pre_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            sh_q        <= '0;
            op_rd_q     <= 1'b0;
            phy_match_q <= 1'b0;
            rd_cap_q    <= 1'b0;
            mdio_o      <= 1'b0;
            mdio_oe_o   <= 1'b0;
            reg_addr_o  <= '0;
            reg_wdata_o <= '0;
            reg_wr_o    <= 1'b0;
            reg_rd_o    <= 1'b0;
        end else begin
            reg_wr_o <= 1'b0;
            reg_rd_o <= 1'b0;
            rd_cap_q <= reg_rd_o;
            if (mdc_rise) begin
                bit_cnt_q <= (state_d != state_q) ? '0 : bit_cnt_q + CNT_W'(1);
                sh_q      <= {sh_q[DATA_W-2:0], mdio_s};
                case (state_q)
                    S_PRE: begin
                        // Count is only ever non-zero while in PRE
                        if (mdio_s) begin
                            if (!pre_full_c) begin
                                pre_cnt_q <= pre_cnt_q + PRE_W'(1);
                            end
                        end else begin
                            pre_cnt_q <= '0;
                        end
                    end
                    S_OP: begin
                        if (bit_cnt_q == CNT_W'(OP_BITS - 1)) begin
                            op_rd_q <= (op_c == MDIO_OP_RD);
                        end
                    end
                    S_PHYAD: begin
                        if (bit_cnt_q == CNT_W'(ADDR_W - 1)) begin
                            phy_match_q <= ({sh_q[ADDR_W-2:0], mdio_s} == PHY_ADDR);
                        end
                    end
                    S_REGAD: begin
                        if (bit_cnt_q == CNT_W'(ADDR_W - 1) && phy_match_q) begin
                            reg_addr_o <= {sh_q[ADDR_W-2:0], mdio_s};
                            reg_rd_o   <= op_rd_q;
                        end
                    end
                    S_TA: begin
                        // First TA bit stays released; drive the 0 of TA next
                        if (op_rd_q && bit_cnt_q == '0) begin
                            mdio_oe_o <= 1'b1;
                            mdio_o    <= 1'b0;
                        end
                        if (rd_shift_c) begin
                            mdio_o <= rd_sh_q[DATA_W-1];
                        end
                    end
                    S_DATA: begin
                        if (op_rd_q) begin
                            if (data_last_c) begin
                                mdio_oe_o <= 1'b0;
                                mdio_o    <= 1'b0;
                            end else begin
                                mdio_o <= rd_sh_q[DATA_W-1];
                            end
                        end else if (data_last_c) begin
                            reg_wdata_o <= {sh_q[DATA_W-2:0], mdio_s};
                            reg_wr_o    <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Read data lands one cycle after reg_rd_o and is then shifted out MSB first
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rd_sh_q <= '0;
        end else if (rd_cap_q) begin
            rd_sh_q <= reg_rdata_i;
        end else if (rd_shift_c) begin
            rd_sh_q <= {rd_sh_q[DATA_W-2:0], 1'b0};
        end
    end

endmodule

// File: tb/tb_mdio_slave.sv
// tb_mdio_slave: scoreboard bench for mdio_slave. Stimulus pushes expected
// strobes / read words; a monitor pops and compares when the DUT presents them.
module tb_mdio_slave;
    import mdio_pkg::*;

    localparam logic [4:0] PHY = 5'h1F;
    localparam int K_WR    = 0;
    localparam int K_RD    = 1;
    localparam int K_RDATA = 2;

    typedef struct {
        int          kind;
        logic [4:0]  addr;
        logic [15:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   oe_hi_cnt = 0;

    logic        clk   = 1'b0;
    logic        rstn  = 1'b0;
    logic        mdc   = 1'b0;
    logic        m_oe  = 1'b1;
    logic        m_val = 1'b1;
    logic        mdio_pad;
    logic        mdio_o, mdio_oe_o, reg_wr_o, reg_rd_o;
    logic [4:0]  reg_addr_o;
    logic [15:0] reg_wdata_o;
    logic [15:0] reg_rdata = 16'h0BAD;
    logic        rd_prev = 1'b0;
    logic [4:0]  rd_prev_addr = 5'h00;
    logic [15:0] rd_obs_word = 16'h0000;
    logic        rd_obs_stb  = 1'b0;
    logic [15:0] rword;

    always #5 clk = ~clk;

    // Pad: slave drive wins, else master, else pull-up
    assign mdio_pad = mdio_oe_o ? mdio_o : (m_oe ? m_val : 1'b1);

    mdio_slave #(.PHY_ADDR(PHY), .PRE_LEN(32)) dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .mdc_i       (mdc),
        .mdio_i      (mdio_pad),
        .mdio_o      (mdio_o),
        .mdio_oe_o   (mdio_oe_o),
        .reg_addr_o  (reg_addr_o),
        .reg_wdata_o (reg_wdata_o),
        .reg_wr_o    (reg_wr_o),
        .reg_rd_o    (reg_rd_o),
        .reg_rdata_i (reg_rdata)
    );

    function automatic logic [15:0] rf_val(input logic [4:0] a);
        case (a)
            5'h0E:   return 16'hA5C3;
            5'h02:   return 16'h0141;
            default: return {11'h000, a};
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void push(input int k, input logic [4:0] a, input logic [15:0] d);
        exp_t e;
        e.kind = k;
        e.addr = a;
        e.data = d;
        sb.push_back(e);
    endfunction

    task automatic sb_pop(input int kind, input logic [4:0] a, input logic [15:0] d);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output kind=%0d addr=%h data=%h required=none at %0t",
                     kind, a, d, $time);
        end else begin
            e = sb.pop_front();
            chk("sb_kind", 32'(kind), 32'(e.kind));
            if (kind != K_RDATA) chk("sb_addr", 32'(a), 32'(e.addr));
            if (kind != K_RD)    chk("sb_data", 32'(d), 32'(e.data));
        end
    endtask

    // Register-file responder: data valid the cycle after reg_rd_o
    always begin
        @(posedge clk);
        #1;
        reg_rdata    = rd_prev ? rf_val(rd_prev_addr) : 16'h0BAD;
        rd_prev      = reg_rd_o;
        rd_prev_addr = reg_addr_o;
    end

    // Monitor
    always begin
        @(posedge clk);
        #2;
        if (mdio_oe_o) oe_hi_cnt++;
        if (reg_wr_o && reg_rd_o) chk("strobe_exclusive", 32'(1), 32'(0));
        if (reg_wr_o)   sb_pop(K_WR, reg_addr_o, reg_wdata_o);
        if (reg_rd_o)   sb_pop(K_RD, reg_addr_o, 16'h0000);
        if (rd_obs_stb) sb_pop(K_RDATA, 5'h00, rd_obs_word);
    end

    // One MDC period; master drives on the low phase, samples at the rise
    task automatic mdc_cycle(input logic drv, input logic b, output logic smp, output logic oe);
        m_oe  = drv;
        m_val = b;
        #40;
        smp = mdio_pad;
        oe  = mdio_oe_o;
        mdc = 1'b1;
        #40;
        mdc = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        logic s, o;
        mdc_cycle(1'b1, b, s, o);
    endtask

    task automatic frame(input int pre_n, input logic [1:0] op, input logic [4:0] phy,
                         input logic [4:0] ra, input logic [15:0] wd, input int abort_at,
                         output logic [15:0] rw);
        logic s, o;
        rw = 16'h0000;
        for (int i = 0; i < pre_n; i++) send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(op[1]);
        send_bit(op[0]);
        for (int i = 4; i >= 0; i--) send_bit(phy[i]);
        for (int i = 4; i >= 0; i--) send_bit(ra[i]);
        if (op == MDIO_OP_RD) begin
            mdc_cycle(1'b0, 1'b1, s, o);
            if (phy == PHY) chk("ta1_oe", 32'(o), 32'(0));
            mdc_cycle(1'b0, 1'b1, s, o);
            if (phy == PHY) begin
                chk("ta2_oe", 32'(o), 32'(1));
                chk("ta2_val", 32'(s), 32'(0));
            end
            for (int j = 0; j < 16; j++) begin
                if (j == abort_at) begin
                    chk("abort_pre_oe", 32'(mdio_oe_o), 32'(1));
                    rstn = 1'b0;
                    #1;
                    chk("abort_oe", 32'(mdio_oe_o), 32'(0));
                    #49;
                    rstn = 1'b1;
                    m_oe = 1'b1;
                    m_val = 1'b1;
                    #100;
                    return;
                end
                mdc_cycle(1'b0, 1'b1, s, o);
                rw = {rw[14:0], s};
            end
            chk("oe_release", 32'(mdio_oe_o), 32'(0));
            m_oe = 1'b1;
            m_val = 1'b1;
        end else begin
            send_bit(1'b1);
            send_bit(1'b0);
            for (int i = 15; i >= 0; i--) send_bit(wd[i]);
        end
        #80;
    endtask

    task automatic post_rdata(input logic [15:0] w);
        rd_obs_word = w;
        rd_obs_stb  = 1'b1;
        #10;
        rd_obs_stb  = 1'b0;
    endtask

    initial begin
        int c0;
        #20;
        chk("rst_oe",    32'(mdio_oe_o),   32'(0));
        chk("rst_mdio",  32'(mdio_o),      32'(0));
        chk("rst_wr",    32'(reg_wr_o),    32'(0));
        chk("rst_rd",    32'(reg_rd_o),    32'(0));
        chk("rst_addr",  32'(reg_addr_o),  32'(0));
        chk("rst_wdata", 32'(reg_wdata_o), 32'(0));
        #10;
        rstn = 1'b1;
        #100;

        // Basic write
        push(K_WR, 5'h0D, 16'h4000);
        frame(32, MDIO_OP_WR, PHY, 5'h0D, 16'h4000, -1, rword);

        // Basic read
        push(K_RD, 5'h0E, 16'h0000);
        push(K_RDATA, 5'h00, 16'hA5C3);
        frame(32, MDIO_OP_RD, PHY, 5'h0E, 16'h0000, -1, rword);
        post_rdata(rword);

        // Read to another PHY: silent, never drives
        c0 = oe_hi_cnt;
        frame(32, MDIO_OP_RD, 5'h03, 5'h02, 16'h0000, -1, rword);
        chk("mismatch_oe_cycles", 32'(oe_hi_cnt - c0), 32'(0));
        push(K_WR, 5'h05, 16'h1234);
        frame(32, MDIO_OP_WR, PHY, 5'h05, 16'h1234, -1, rword);

        // Broken preamble then a write: ignored
        for (int i = 0; i < 20; i++) send_bit(1'b1);
        send_bit(1'b0);
        frame(12, MDIO_OP_WR, PHY, 5'h0D, 16'hBEEF, -1, rword);

        // Illegal OP 11: ignored, then a good frame recovers
        frame(32, 2'b11, PHY, 5'h0D, 16'hFFFF, -1, rword);
        push(K_WR, 5'h0A, 16'h00FF);
        frame(32, MDIO_OP_WR, PHY, 5'h0A, 16'h00FF, -1, rword);

        // Reset while bit 8 of read data is on the pad
        push(K_RD, 5'h0E, 16'h0000);
        frame(32, MDIO_OP_RD, PHY, 5'h0E, 16'h0000, 7, rword);
        push(K_WR, 5'h11, 16'hC0DE);
        frame(32, MDIO_OP_WR, PHY, 5'h11, 16'hC0DE, -1, rword);

        // Back-to-back writes separated by a single idle 1
        push(K_WR, 5'h01, 16'hAAAA);
        frame(32, MDIO_OP_WR, PHY, 5'h01, 16'hAAAA, -1, rword);
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
        push(K_WR, 5'h02, 16'h5555);
`endif
        frame(1, MDIO_OP_WR, PHY, 5'h02, 16'h5555, -1, rword);

        #500;
        chk("sb_empty", 32'(sb.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mdio_slave.md
MDIO_SLAVE -- requirements
Module: mdio_slave

Interface
REQ-001 SHALL have parameter PHY_ADDR, default 5'h1F: PHYAD value this slave answers to.
REQ-002 SHALL have parameter PRE_LEN, default 32: number of consecutive 1 bits that form a valid preamble.
REQ-003 SHALL have port clk_i, input, 1: system clock, at least 4x MDC frequency; the only clock.
REQ-004 SHALL have port rstn_i, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port mdc_i, input, 1: MDIO management clock from the pad, asynchronous to clk_i.
REQ-006 SHALL have port mdio_i, input, 1: MDIO pad input data.
REQ-007 SHALL have port mdio_o, output, 1: MDIO pad output data.
REQ-008 SHALL have port mdio_oe_o, output, 1: MDIO pad output enable, active high.
REQ-009 SHALL have port reg_addr_o, output, 5: REGAD of the current frame.
REQ-010 SHALL have port reg_wdata_o, output, 16: write data.
REQ-011 SHALL have port reg_wr_o, output, 1: one-cycle write strobe.
REQ-012 SHALL have port reg_rd_o, output, 1: one-cycle read strobe.
REQ-013 SHALL have port reg_rdata_i, input, 16: read data, valid one clk_i cycle after reg_rd_o.

Function
REQ-014 SHALL pass mdc_i and mdio_i through 2-flop synchronizers.
REQ-015 SHALL generate a one-cycle internal mdc_rise pulse from the synchronized MDC.
REQ-016 SHALL sample MDIO bits only on mdc_rise.
REQ-017 SHALL implement Clause-22 frame FSM states: PRE, ST, OP, PHYAD, REGAD, TA, DATA, SKIP.
- PRE: counts consecutive 1s, saturating at PRE_LEN; any 0 before saturation clears the count.
- PRE to ST: the first 0 after saturation, taken as ST bit 0.
REQ-018 ST: a second bit of 1 SHALL go to OP; otherwise the FSM SHALL return to PRE with the count cleared.
REQ-019 OP: 2'b01 = write, 2'b10 = read; 2'b00 and 2'b11 SHALL return to PRE.
REQ-020 PHYAD and REGAD SHALL shift in MSB first, 5 bits each.
REQ-021 A PHYAD not equal to PHY_ADDR SHALL go to SKIP, which counts the 18 remaining bits then returns to PRE with no strobe and no drive.
REQ-022 Read: reg_rd_o SHALL pulse on the clk_i cycle after the REGAD LSB is sampled, with reg_addr_o valid in the same cycle.
REQ-023 Read: reg_rdata_i SHALL be captured into a 16-bit shift register one cycle later.
REQ-024 Read turnaround:
- mdio_oe_o = 0 during the first TA bit.
- On the mdc_rise that ends the first TA bit: mdio_oe_o = 1, mdio_o = 0.
- On each following mdc_rise: shift out data MSB first.
- On the mdc_rise after bit 0 has been driven: mdio_oe_o = 0.
REQ-025 Write: TA bits SHALL be ignored; 16 data bits SHALL shift in MSB first.
REQ-026 Write: reg_wdata_o and reg_wr_o (one cycle) SHALL update on the clk_i cycle after the LSB is sampled.
REQ-027 After DATA, the FSM SHALL go to PRE with the count cleared; back-to-back frames require a full preamble unless REQ-033 applies.
REQ-028 reg_wr_o and reg_rd_o SHALL never be asserted in the same cycle.
REQ-029 Each strobe SHALL be exactly one clk_i cycle per frame.

Reset
REQ-030 On rstn_i low:
- FSM = PRE, preamble count = 0.
- mdio_oe_o = 0, mdio_o = 0, reg_wr_o = 0, reg_rd_o = 0.
- reg_addr_o = 0, reg_wdata_o = 0.
- Synchronizer flops = 0.
REQ-031 Reset asserted mid-frame SHALL abort the frame.
- mdio_oe_o SHALL release immediately (asynchronously).
- No strobe SHALL be issued.
- After reset release, a full preamble SHALL be required.

Configuration
REQ-032 Macro MDIO_PREAMBLE_SUPPRESS_EN SHALL control preamble suppression.
REQ-033 With MDIO_PREAMBLE_SUPPRESS_EN defined: after a completed addressed frame, PRE SHALL accept ST after at least 1 idle 1-bit.
REQ-034 Without MDIO_PREAMBLE_SUPPRESS_EN: PRE_LEN ones SHALL always be required.

Structure
REQ-035 Package mdio_pkg SHALL hold:
- the FSM state enum;
- OP encodings MDIO_OP_WR = 2'b01, MDIO_OP_RD = 2'b10;
- ST code 2'b01.
REQ-036 Sub-module mdio_sync_edge SHALL hold the 2-flop synchronizer and rise detect, instantiated once for MDC and once for MDIO (edge output unused for MDIO).
REQ-037 The rest of the logic SHALL be flat in mdio_slave.

Verification
REQ-038 Write frame: 32 ones, ST 01, OP 01, PHYAD 1F, REGAD 0D, TA 10, data 16'h4000 -> a single reg_wr_o pulse with reg_addr_o = 0D and reg_wdata_o = 16'h4000.
REQ-039 Read frame: PHYAD 1F, REGAD 0E, reg_rdata_i = 16'hA5C3 -> one reg_rd_o pulse; MDIO shows Z, 0 at TA, then A5C3 MSB first; oe releases after bit 0.
REQ-040 PHYAD mismatch: PHYAD 03 read -> no strobe, mdio_oe_o stays 0 for the whole frame; the next valid frame is accepted.
REQ-041 Preamble broken: 20 ones, one 0, 12 ones, ST, write frame -> ignored. A separate case with OP 11 -> FSM back to PRE with no strobe.
REQ-042 Reset mid-read: assert rstn_i at data bit 8 -> mdio_oe_o = 0 at once; a following full write frame succeeds.
REQ-043 With MDIO_PREAMBLE_SUPPRESS_EN: back-to-back writes with a 1-bit gap -> both accepted. Without it -> only the first accepted.
